// File: rtl/ivs_pkg.sv
// ivs_pkg: shared address map, AHB encodings and FSM states for the IVS config slave
package ivs_pkg;
  localparam logic [11:0] A_GLB_CTRL = 12'h000;
  localparam logic [11:0] A_SW_RST   = 12'h004;
  localparam logic [11:0] A_STATUS   = 12'h008;
  localparam logic [11:0] A_LOCK     = 12'h00C;
  localparam logic [11:0] A_PAR_BASE = 12'h100;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_WAIT, S_RD, S_ERR1, S_ERR2} ivs_state_e;
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    return size == 2'd0 ? 4'b0001 << off : size == 2'd1 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/ivs_byte_merge.sv
// ivs_byte_merge: replaces the byte lanes of a word selected by transfer size and offset
module ivs_byte_merge
  import ivs_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  output logic [31:0] o_word
);
  logic [3:0] w_be;
  assign w_be = byte_en(i_size, i_off);
  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign o_word[8*b +: 8] = w_be[b] ? i_wdata[8*b +: 8] : i_old[8*b +: 8];
  end
endmodule

// File: rtl/ivs_cfg_slv.sv
// ivs_cfg_slv: AHB-Lite configuration slave with cfg_par bank, global control,
// soft-reset pulse, status readback, sticky lock, read wait states and ERROR response
module ivs_cfg_slv
  import ivs_pkg::*;
#(
  parameter int          NUM_PAR   = 8,
  parameter int          RD_WAIT   = 0,
  parameter int          SWRST_LEN = 4,
  parameter logic [31:0] PAR_RST   = 32'h0
) (
  input  logic                  hclk,
  input  logic                  hrst,
  input  logic                  hsel,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [31:0]           haddr,
  input  logic [31:0]           hwdata,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hready_in,
  output logic                  hready_out,
  output logic [1:0]            hresp,
  output logic [31:0]           hrdata,
  output logic [NUM_PAR*32-1:0] cfg_par,
  output logic [31:0]           glb_ctrl,
  output logic                  sw_rst,
  input  logic [31:0]           sts_in
);
  localparam int PW = NUM_PAR > 1 ? $clog2(NUM_PAR) : 1;
  ivs_state_e   r_st, w_st_nxt;
  logic [11:0]  r_addr;
  logic [1:0]   r_size;
  logic [2:0]   r_wcnt;
  logic [7:0]   r_swcnt;
  logic [31:0]  r_par [NUM_PAR];
  logic [31:0]  r_glb;
  logic         r_lock;
  logic [11:0]  w_wa;
  logic [PW-1:0] w_pidx;
  logic         w_par_sel, w_wr, w_lock_eff;
  logic [31:0]  w_cur, w_new;
  logic         w_acc, w_in_par, w_in_map, w_mis, w_err;
  logic         w_unused;
  assign w_unused = ^{hburst, hprot, haddr[31:12], htrans[0], r_addr[7:2]};
  assign w_wa      = {r_addr[11:2], 2'b00};
  assign w_pidx    = r_addr[2 +: PW];
  assign w_par_sel = r_addr[11:8] == A_PAR_BASE[11:8];
  assign w_wr      = r_st == S_WR;
  assign w_cur = w_par_sel ? r_par[w_pidx] :
                 w_wa == A_GLB_CTRL ? r_glb :
                 w_wa == A_STATUS ? sts_in :
                 w_wa == A_LOCK ? {31'b0, r_lock} : '0;
  ivs_byte_merge u_merge (
    .i_old  (w_cur),
    .i_wdata(hwdata),
    .i_size (r_size),
    .i_off  (r_addr[1:0]),
    .o_word (w_new)
  );
  // a LOCK write in its data phase already blocks a pipelined cfg_par write behind it
  assign w_lock_eff = r_lock | (w_wr && w_wa == A_LOCK && w_new[0]);
  assign w_in_par = haddr[11:8] == A_PAR_BASE[11:8] && {1'b0, haddr[7:2]} < 7'(NUM_PAR);
  assign w_in_map = w_in_par || haddr[11:4] == 8'h00;
  assign w_mis    = (hsize == 3'd1 && haddr[0]) || (hsize == 3'd2 && haddr[1:0] != 2'b00);
  assign w_err    = !w_in_map || hsize > 3'd2 || w_mis ||
                    (hwrite && {haddr[11:2], 2'b00} == A_STATUS) ||
                    (hwrite && w_in_par && w_lock_eff);
  assign w_acc    = hsel && htrans[1] && hready_in && hready_out;
  always_comb begin
    w_st_nxt   = r_st == S_ERR1 ? S_ERR2 :
                 r_st == S_RD_WAIT ? (r_wcnt == 3'd0 ? S_RD : S_RD_WAIT) :
                 !w_acc ? S_IDLE :
                 w_err ? S_ERR1 :
                 hwrite ? S_WR :
                 RD_WAIT > 0 ? S_RD_WAIT : S_RD;
    hready_out = !(r_st == S_ERR1 || r_st == S_RD_WAIT);
    hresp      = (r_st == S_ERR1 || r_st == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    hrdata     = r_st == S_RD ? w_cur : '0;
  end
  always_ff @(posedge hclk) begin
    if (hrst) r_st <= S_IDLE;
    else r_st <= w_st_nxt;
  end
  always_ff @(posedge hclk) begin
    if (hrst) begin
      r_addr  <= '0;
      r_size  <= '0;
      r_wcnt  <= '0;
      r_swcnt <= '0;
      r_glb   <= '0;
      r_lock  <= 1'b0;
      for (int i = 0; i < NUM_PAR; i++) r_par[i] <= PAR_RST;
    end else begin
      if (w_acc) begin
        r_addr <= haddr[11:0];
        r_size <= hsize[1:0];
        r_wcnt <= 3'(RD_WAIT - 1);
      end else if (r_st == S_RD_WAIT) begin
        r_wcnt <= r_wcnt - 3'd1;
      end
      if (w_wr && w_par_sel) r_par[w_pidx] <= w_new;
      if (w_wr && w_wa == A_GLB_CTRL) r_glb <= w_new;
      if (w_wr && w_wa == A_LOCK) r_lock <= r_lock | w_new[0];
      r_swcnt <= (w_wr && w_wa == A_SW_RST && w_new[0]) ? 8'(SWRST_LEN) :
                 r_swcnt != 8'd0 ? r_swcnt - 8'd1 : 8'd0;
    end
  end
  for (genvar p = 0; p < NUM_PAR; p++) begin : g_par
    assign cfg_par[32*p +: 32] = r_par[p];
  end
  assign glb_ctrl = r_glb;
  assign sw_rst   = r_swcnt != 8'd0;
endmodule

// File: tb/tb_ivs_cfg_slv.sv
// tb_ivs_cfg_slv: directed bench for ivs_cfg_slv; one instance without and one with read wait states
module tb_ivs_cfg_slv;
  localparam logic [31:0] PAR0 = 32'hA5A5_0001;
  logic         hclk, hrst, hsel0, hsel3, hwrite;
  logic [1:0]   htrans;
  logic [31:0]  haddr, hwdata, sts_in;
  logic [2:0]   hsize, hburst;
  logic [3:0]   hprot;
  logic         hready_in0, hready_out0, sw_rst0, hready_in3, hready_out3, sw_rst3;
  logic [1:0]   hresp0, hresp3;
  logic [31:0]  hrdata0, glb_ctrl0, hrdata3, glb_ctrl3;
  logic [255:0] cfg_par0;
  logic [127:0] cfg_par3;
  int n_cmp = 0;
  int n_bad = 0;
  assign hready_in0 = hready_out0;
  assign hready_in3 = hready_out3;

  ivs_cfg_slv #(.NUM_PAR(8), .RD_WAIT(0), .SWRST_LEN(4), .PAR_RST(PAR0)) u_dut0 (
    .hclk(hclk), .hrst(hrst), .hsel(hsel0), .htrans(htrans), .hwrite(hwrite), .haddr(haddr),
    .hwdata(hwdata), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready_in(hready_in0),
    .hready_out(hready_out0), .hresp(hresp0), .hrdata(hrdata0), .cfg_par(cfg_par0),
    .glb_ctrl(glb_ctrl0), .sw_rst(sw_rst0), .sts_in(sts_in));
  ivs_cfg_slv #(.NUM_PAR(4), .RD_WAIT(3), .SWRST_LEN(4), .PAR_RST(32'h0)) u_dut3 (
    .hclk(hclk), .hrst(hrst), .hsel(hsel3), .htrans(htrans), .hwrite(hwrite), .haddr(haddr),
    .hwdata(hwdata), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready_in(hready_in3),
    .hready_out(hready_out3), .hresp(hresp3), .hrdata(hrdata3), .cfg_par(cfg_par3),
    .glb_ctrl(glb_ctrl3), .sw_rst(sw_rst3), .sts_in(sts_in));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask
  task automatic addr(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    htrans = 2'b10;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask
  task automatic idle_bus;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic test_reset;
    hrst = 1'b1;
    tick;
    tick;
    n_cmp++; if (hready_out0 !== 1'b1) begin n_bad++; $display("FAIL rst_hready: got %b exp 1", hready_out0); end
    n_cmp++; if (hresp0 !== 2'b00) begin n_bad++; $display("FAIL rst_hresp: got %b exp 00", hresp0); end
    n_cmp++; if (hrdata0 !== 32'h0) begin n_bad++; $display("FAIL rst_hrdata: got %h exp 0", hrdata0); end
    n_cmp++; if (cfg_par0 !== {8{PAR0}}) begin n_bad++; $display("FAIL rst_cfg_par: got %h exp %h", cfg_par0, {8{PAR0}}); end
    n_cmp++; if (glb_ctrl0 !== 32'h0 || sw_rst0 !== 1'b0) begin n_bad++; $display("FAIL rst_glb_sw: got %h/%b exp 0/0", glb_ctrl0, sw_rst0); end
    n_cmp++; if (cfg_par3 !== 128'h0 || hready_out3 !== 1'b1) begin n_bad++; $display("FAIL rst_dut3: got %h/%b exp 0/1", cfg_par3, hready_out3); end
    hrst = 1'b0;
    hsel0 = 1'b1;
    addr(1'b0, 32'h100, 3'd2);
    tick;
    n_cmp++; if (hrdata0 !== PAR0 || hresp0 !== 2'b00 || hready_out0 !== 1'b1) begin n_bad++; $display("FAIL rd_par0_rst: got %h/%b/%b exp %h/00/1", hrdata0, hresp0, hready_out0, PAR0); end
    addr(1'b0, 32'h000, 3'd2);
    tick;
    n_cmp++; if (hrdata0 !== 32'h0 || hresp0 !== 2'b00) begin n_bad++; $display("FAIL rd_glb_rst: got %h/%b exp 0/00", hrdata0, hresp0); end
    addr(1'b0, 32'h00C, 3'd2);
    tick;
    n_cmp++; if (hrdata0 !== 32'h0 || hresp0 !== 2'b00) begin n_bad++; $display("FAIL rd_lock_rst: got %h/%b exp 0/00", hrdata0, hresp0); end
    idle_bus;
    tick;
  endtask

  task automatic test_write_read;
    hsel0 = 1'b1;
    addr(1'b1, 32'h104, 3'd2);
    tick;
    hwdata = 32'hDEADBEEF;
    addr(1'b0, 32'h104, 3'd2);
    n_cmp++; if (hready_out0 !== 1'b1 || hresp0 !== 2'b00) begin n_bad++; $display("FAIL wr_phase: got %b/%b exp 1/00", hready_out0, hresp0); end
    tick;
    n_cmp++; if (hrdata0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL raw_b2b: got %h exp deadbeef", hrdata0); end
    n_cmp++; if (cfg_par0[63:32] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL cfg_par1: got %h exp deadbeef", cfg_par0[63:32]); end
    addr(1'b1, 32'h106, 3'd0);
    tick;
    hwdata = 32'hAA55CC33;
    addr(1'b0, 32'h104, 3'd2);
    tick;
    n_cmp++; if (hrdata0 !== 32'hDE55BEEF) begin n_bad++; $display("FAIL byte_wr: got %h exp de55beef", hrdata0); end
    addr(1'b1, 32'h101, 3'd1);
    tick;
    idle_bus;
    n_cmp++; if (hready_out0 !== 1'b0 || hresp0 !== 2'b01) begin n_bad++; $display("FAIL hw_mis_err1: got %b/%b exp 0/01", hready_out0, hresp0); end
    tick;
    n_cmp++; if (hready_out0 !== 1'b1 || hresp0 !== 2'b01) begin n_bad++; $display("FAIL hw_mis_err2: got %b/%b exp 1/01", hready_out0, hresp0); end
    tick;
    n_cmp++; if (cfg_par0[63:32] !== 32'hDE55BEEF || hresp0 !== 2'b00) begin n_bad++; $display("FAIL after_err: got %h/%b exp de55beef/00", cfg_par0[63:32], hresp0); end
  endtask

  task automatic test_rd_wait;
    int n;
    hsel0 = 1'b0;
    hsel3 = 1'b1;
    sts_in = 32'h12345678;
    addr(1'b0, 32'h008, 3'd2);
    tick;
    idle_bus;
    n_cmp++; if (hrdata3 !== 32'h0) begin n_bad++; $display("FAIL wait_hrdata: got %h exp 0", hrdata3); end
    n = 0;
    while (hready_out3 === 1'b0 && n < 20) begin
      n++;
      tick;
    end
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL wait_cycles: got %0d exp 3", n); end
    n_cmp++; if (hrdata3 !== 32'h12345678 || hresp3 !== 2'b00) begin n_bad++; $display("FAIL wait_status: got %h/%b exp 12345678/00", hrdata3, hresp3); end
    tick;
    hsel3 = 1'b0;
  endtask

  task automatic test_errors;
    logic [31:0] ea [5] = '{32'h200, 32'h008, 32'h120, 32'h000, 32'h102};
    logic        ew [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  es [5] = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd2};
    hsel0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      addr(ew[i], ea[i], es[i]);
      tick;
      idle_bus;
      hwdata = 32'hFFFFFFFF;
      n_cmp++; if (hready_out0 !== 1'b0 || hresp0 !== 2'b01) begin n_bad++; $display("FAIL err1_%0d: got %b/%b exp 0/01", i, hready_out0, hresp0); end
      tick;
      n_cmp++; if (hready_out0 !== 1'b1 || hresp0 !== 2'b01 || hrdata0 !== 32'h0) begin n_bad++; $display("FAIL err2_%0d: got %b/%b/%h exp 1/01/0", i, hready_out0, hresp0, hrdata0); end
      tick;
    end
    n_cmp++; if (cfg_par0[31:0] !== PAR0 || glb_ctrl0 !== 32'h0) begin n_bad++; $display("FAIL err_nochg: got %h/%h exp %h/0", cfg_par0[31:0], glb_ctrl0, PAR0); end
  endtask

  task automatic test_lock;
    hsel0 = 1'b1;
    addr(1'b1, 32'h00C, 3'd2);
    tick;
    hwdata = 32'h1;
    addr(1'b1, 32'h100, 3'd2);
    tick;
    idle_bus;
    n_cmp++; if (hready_out0 !== 1'b0 || hresp0 !== 2'b01) begin n_bad++; $display("FAIL lock_err1: got %b/%b exp 0/01", hready_out0, hresp0); end
    tick;
    hwdata = 32'hFFFFFFFF;
    n_cmp++; if (hready_out0 !== 1'b1 || hresp0 !== 2'b01) begin n_bad++; $display("FAIL lock_err2: got %b/%b exp 1/01", hready_out0, hresp0); end
    tick;
    n_cmp++; if (cfg_par0[31:0] !== PAR0) begin n_bad++; $display("FAIL lock_par: got %h exp %h", cfg_par0[31:0], PAR0); end
    addr(1'b1, 32'h000, 3'd2);
    tick;
    hwdata = 32'h0000CAFE;
    addr(1'b0, 32'h00C, 3'd2);
    n_cmp++; if (hready_out0 !== 1'b1 || hresp0 !== 2'b00) begin n_bad++; $display("FAIL lock_glb_wr: got %b/%b exp 1/00", hready_out0, hresp0); end
    tick;
    idle_bus;
    n_cmp++; if (hrdata0 !== 32'h1) begin n_bad++; $display("FAIL lock_rd: got %h exp 1", hrdata0); end
    n_cmp++; if (glb_ctrl0 !== 32'h0000CAFE) begin n_bad++; $display("FAIL glb_val: got %h exp 0000cafe", glb_ctrl0); end
    tick;
  endtask

  task automatic test_sw_rst;
    int cnt;
    hsel0 = 1'b1;
    addr(1'b0, 32'h004, 3'd2);
    tick;
    n_cmp++; if (hrdata0 !== 32'h0 || hresp0 !== 2'b00) begin n_bad++; $display("FAIL swrst_rd: got %h/%b exp 0/00", hrdata0, hresp0); end
    addr(1'b1, 32'h004, 3'd2);
    tick;
    hwdata = 32'h1;
    idle_bus;
    n_cmp++; if (sw_rst0 !== 1'b0) begin n_bad++; $display("FAIL swrst_wr_phase: got %b exp 0", sw_rst0); end
    tick;
    cnt = sw_rst0 ? 1 : 0;
    addr(1'b1, 32'h004, 3'd2);
    tick;
    hwdata = 32'h1;
    idle_bus;
    cnt += sw_rst0 ? 1 : 0;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (sw_rst0 !== 1'b1) break;
      cnt++;
    end
    n_cmp++; if (cnt !== 6) begin n_bad++; $display("FAIL swrst_len: got %0d exp 6", cnt); end
    addr(1'b1, 32'h004, 3'd2);
    tick;
    hwdata = 32'h1;
    idle_bus;
    tick;
    tick;
    n_cmp++; if (sw_rst0 !== 1'b1 || glb_ctrl0 !== 32'h0000CAFE) begin n_bad++; $display("FAIL swrst_mid: got %b/%h exp 1/0000cafe", sw_rst0, glb_ctrl0); end
    hrst = 1'b1;
    tick;
    hrst = 1'b0;
    n_cmp++; if (sw_rst0 !== 1'b0) begin n_bad++; $display("FAIL swrst_hrst: got %b exp 0", sw_rst0); end
    n_cmp++; if (glb_ctrl0 !== 32'h0 || cfg_par0 !== {8{PAR0}} || hready_out0 !== 1'b1) begin n_bad++; $display("FAIL hrst_regs: got %h/%h/%b exp 0/%h/1", glb_ctrl0, cfg_par0[31:0], hready_out0, PAR0); end
  endtask

  initial begin
    hrst = 1'b1; hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    haddr = '0; hwdata = '0; hsize = 3'd2; hburst = 3'd0; hprot = 4'd0; sts_in = '0;
    test_reset;
    test_write_read;
    test_rd_wait;
    test_errors;
    test_lock;
    test_sw_rst;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
